// File: rtl/sent_tx_frame_sched_if.sv
// Bundle between the SENT frame scheduler, the TX data register and the pulse encoder.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface sent_tx_frame_sched_if;
    logic        enable;
    logic [2:0]  cfg_mode;
    logic [3:0]  cfg_status;
    logic [2:0]  load_bit;
    logic        done;
    logic [15:0] data_f1;
    logic [11:0] data_f2;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  frame_status;
    logic [23:0] frame_data;
    logic [2:0]  frame_len;
    logic [3:0]  frame_crc;
    logic        busy;
    logic        err_timeout;
    logic        err_mode;

    modport master (
        input  enable, cfg_mode, cfg_status, done, data_f1, data_f2, frame_ready,
        output load_bit, frame_valid, frame_status, frame_data, frame_len, frame_crc,
        output busy, err_timeout, err_mode
    );

    modport slave (
        output enable, cfg_mode, cfg_status, done, data_f1, data_f2, frame_ready,
        input  load_bit, frame_valid, frame_status, frame_data, frame_len, frame_crc,
        input  busy, err_timeout, err_mode
    );
endinterface

// File: rtl/sent_tx_frame_sched.sv
// SENT fast-channel frame scheduler: requests data from the TX register, packs
// the nibbles, computes the J2716 CRC4 and offers the frame over valid/ready.
module sent_tx_frame_sched #(
    parameter int          TIMEOUT  = 64,
    parameter logic [3:0]  CRC_SEED = 4'b0101
) (
    input  logic                          clk_tx,
    input  logic                          reset_tx,
    sent_tx_frame_sched_if.master         sched
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CRC  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_mode;
    logic [3:0]          r_status;
    logic [2:0]          r_load_bit;
    logic [WAIT_W-1:0]   r_wait;
    logic [7:0]          r_rcnt;
    logic [23:0]         r_data;
    logic [23:0]         r_shift;
    logic [2:0]          r_len;
    logic [2:0]          r_nib_cnt;
    logic [3:0]          r_crc;
    logic [3:0]          r_frame_crc;
    logic                r_valid;
    logic                r_busy;
    logic                r_err_timeout;
    logic                r_err_mode;

    logic [23:0]         w_packed;
    logic [2:0]          w_len;
    logic [3:0]          w_crc_next;

    function automatic logic [23:0] pack_nibbles(input logic [2:0]  mode,
                                                 input logic [15:0] f1,
                                                 input logic [11:0] f2,
                                                 input logic [7:0]  cnt);
        case (mode)
            3'b001:  return {f1[11:0], f2[3:0], f2[7:4], f2[11:8]};
            3'b010:  return {f1[11:0], 12'h000};
            3'b011:  return {f1[11:0], cnt[3:0], 8'h00};
            3'b100:  return {f1[11:0], cnt, ~f1[11:8]};
            3'b101:  return {f1[11:0], 12'h000};
            3'b110:  return {f1[13:0], f2[5:0], 4'h0};
            3'b111:  return {f1, f2[3:0], 4'h0};
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [2:0] nibble_count(input logic [2:0] mode);
        case (mode)
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    // One CRC step consumes a whole nibble, msb first, polynomial x^4+x^3+x^2+1.
    function automatic logic [3:0] crc4_nibble(input logic [3:0] crc_in,
                                               input logic [3:0] nib);
        logic [3:0] c;
        logic       fb;
        // NOTE: blocking assignments are correct here; this is combinational
        // scratch state inside a function, evaluated in order within one call.
        c = crc_in;
        for (int i = 3; i >= 0; i--) begin
            fb = c[3] ^ nib[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
        end
        return c;
    endfunction

    assign w_packed   = pack_nibbles(r_mode, sched.data_f1, sched.data_f2, r_rcnt);
    assign w_len      = nibble_count(r_mode);
    // Unused low nibbles are zero, so shifting past len feeds the augmenting zero.
    assign w_crc_next = crc4_nibble(r_crc, r_shift[23:20]);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset also clears load_bit without a clock.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_state       <= ST_IDLE;
            r_mode        <= 3'd0;
            r_status      <= 4'd0;
            r_load_bit    <= 3'd0;
            r_wait        <= '0;
            r_rcnt        <= 8'd0;
            r_data        <= 24'd0;
            r_shift       <= 24'd0;
            r_len         <= 3'd0;
            r_nib_cnt     <= 3'd0;
            r_crc         <= 4'd0;
            r_frame_crc   <= 4'd0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_mode    <= 1'b0;
        end else begin
            r_err_timeout <= 1'b0;
            r_err_mode    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sched.enable) begin
                        if (sched.cfg_mode != 3'd0) begin
                            r_mode     <= sched.cfg_mode;
                            r_status   <= sched.cfg_status;
                            r_load_bit <= sched.cfg_mode;
                            r_wait     <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_err_mode <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (sched.done) begin
                        r_load_bit <= 3'd0;
                        r_data     <= w_packed;
                        r_shift    <= w_packed;
                        r_len      <= w_len;
                        r_nib_cnt  <= 3'd0;
                        r_crc      <= CRC_SEED;
                        r_state    <= ST_CRC;
                    end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                        r_load_bit    <= 3'd0;
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                ST_CRC: begin
                    r_crc   <= w_crc_next;
                    r_shift <= {r_shift[19:0], 4'h0};
                    if (r_nib_cnt == r_len) begin
                        r_frame_crc <= w_crc_next;
                        r_valid     <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_nib_cnt <= r_nib_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (sched.frame_ready) begin
                        r_valid <= 1'b0;
                        r_rcnt  <= r_rcnt + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sched.load_bit     = r_load_bit;
    assign sched.frame_valid  = r_valid;
    assign sched.frame_status = r_status;
    assign sched.frame_data   = r_data;
    assign sched.frame_len    = r_len;
    assign sched.frame_crc    = r_frame_crc;
    assign sched.busy         = r_busy;
    assign sched.err_timeout  = r_err_timeout;
    assign sched.err_mode     = r_err_mode;

endmodule

// File: tb/tb_sent_tx_frame_sched.sv
// Self-checking bench for sent_tx_frame_sched: vector table plus corner-case
// sequences, with accepted frames compared against a scoreboard queue.
`timescale 1ns/1ps
module tb_sent_tx_frame_sched;

    typedef struct {
        logic [2:0]  mode;
        logic [3:0]  status;
        logic [15:0] f1;
        logic [11:0] f2;
        int          ready_dly;
        logic [23:0] exp_data;
        logic [2:0]  exp_len;
        logic        crc_known;
        logic [3:0]  exp_crc;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic [2:0]  len;
        logic [3:0]  crc;
        logic [3:0]  status;
    } exp_t;

    logic clk_tx = 1'b0;
    logic reset_tx;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];

    always #5 clk_tx = ~clk_tx;

    sent_tx_frame_sched_if bus();

    sent_tx_frame_sched #(
        .TIMEOUT  (64),
        .CRC_SEED (4'b0101)
    ) dut (
        .clk_tx   (clk_tx),
        .reset_tx (reset_tx),
        .sched    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC over a flat bit stream: len data nibbles then four zero bits.
    function automatic logic [3:0] crc_ref(input logic [23:0] data, input logic [2:0] len);
        logic [3:0] c;
        logic       b;
        logic       fb;
        c = 4'b0101;
        for (int k = 0; k < 4 * int'(len) + 4; k++) begin
            b  = (k < 4 * int'(len)) ? data[23 - k] : 1'b0;
            fb = c[3] ^ b;
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b1101;
        end
        return c;
    endfunction

    // Scoreboard: compare whenever the handshake completes on the next edge.
    always @(negedge clk_tx) begin
        if (!reset_tx && bus.frame_valid && bus.frame_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_frame: got data 0x%0h, expected no frame", bus.frame_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_data",   bus.frame_data,   mon_e.data);
                check("sb_len",    bus.frame_len,    mon_e.len);
                check("sb_crc",    bus.frame_crc,    mon_e.crc);
                check("sb_status", bus.frame_status, mon_e.status);
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        exp_t        e;
        logic [35:0] snap;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk_tx);
            n++;
        end
        @(negedge clk_tx);
        bus.frame_ready = (v.ready_dly == 0);
        bus.cfg_mode    = v.mode;
        bus.cfg_status  = v.status;
        bus.enable      = 1'b1;
        @(negedge clk_tx);
        check({tag, "_load_bit"}, bus.load_bit, v.mode);
        check({tag, "_busy"}, bus.busy, 1'b1);
        bus.enable     = 1'b0;
        bus.cfg_mode   = 3'd0;
        bus.cfg_status = 4'd0;
        repeat (2) @(negedge clk_tx);
        check({tag, "_load_held"}, bus.load_bit, v.mode);
        bus.done    = 1'b1;
        bus.data_f1 = v.f1;
        bus.data_f2 = v.f2;
        e.data   = v.exp_data;
        e.len    = v.exp_len;
        e.crc    = v.crc_known ? v.exp_crc : crc_ref(v.exp_data, v.exp_len);
        e.status = v.status;
        sb_q.push_back(e);
        @(negedge clk_tx);
        bus.done    = 1'b0;
        bus.data_f1 = 16'hDEAD;
        bus.data_f2 = 12'hBAD;
        check({tag, "_load_cleared"}, bus.load_bit, 3'd0);
        n = 0;
        while (!bus.frame_valid && n < 20) begin
            @(negedge clk_tx);
            n++;
        end
        check({tag, "_latency"}, n, v.exp_len + 1);
        if (v.ready_dly > 0) begin
            snap = {bus.frame_status, bus.frame_data, bus.frame_len, bus.frame_crc, bus.frame_valid};
            repeat (v.ready_dly) begin
                @(negedge clk_tx);
                check({tag, "_hold_stable"},
                      {bus.frame_status, bus.frame_data, bus.frame_len, bus.frame_crc, bus.frame_valid},
                      snap);
            end
            @(posedge clk_tx);
            #1 bus.frame_ready = 1'b1;
        end
        n = 0;
        while (bus.frame_valid && n < 20) begin
            @(negedge clk_tx);
            n++;
        end
        check({tag, "_accepted"}, bus.frame_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   load_cycles;
        logic saw_valid;
        vec_t v;

        //            mode    stat  f1        f2       dly data        len   known crc
        vecs[0] = '{3'b010, 4'h1, 16'h0000, 12'h000, 0,  24'h000000, 3'd3, 1'b1, 4'b1001};
        vecs[1] = '{3'b001, 4'h2, 16'h0000, 12'h000, 0,  24'h000000, 3'd6, 1'b1, 4'b0101};
        vecs[2] = '{3'b001, 4'h3, 16'h0ABC, 12'h123, 10, 24'hABC321, 3'd6, 1'b0, 4'h0};
        vecs[3] = '{3'b011, 4'h4, 16'h05A5, 12'h000, 0,  24'h5A5300, 3'd4, 1'b0, 4'h0};
        vecs[4] = '{3'b100, 4'h5, 16'h09F0, 12'h000, 0,  24'h9F0046, 3'd6, 1'b0, 4'h0};
        vecs[5] = '{3'b101, 4'h6, 16'hF123, 12'hFFF, 0,  24'h123000, 3'd6, 1'b0, 4'h0};
        vecs[6] = '{3'b110, 4'h7, 16'h8001, 12'h041, 0,  24'h000410, 3'd6, 1'b0, 4'h0};
        vecs[7] = '{3'b111, 4'h8, 16'hBEEF, 12'h00D, 3,  24'hBEEFD0, 3'd6, 1'b0, 4'h0};
        vecs[8] = '{3'b010, 4'hF, 16'hFFFF, 12'hFFF, 0,  24'hFFF000, 3'd3, 1'b0, 4'h0};

        reset_tx        = 1'b1;
        bus.enable      = 1'b0;
        bus.cfg_mode    = 3'd0;
        bus.cfg_status  = 4'd0;
        bus.done        = 1'b0;
        bus.data_f1     = 16'd0;
        bus.data_f2     = 12'd0;
        bus.frame_ready = 1'b1;
        repeat (3) @(negedge clk_tx);
        check("reset_outputs",
              {bus.load_bit, bus.frame_valid, bus.frame_status, bus.frame_data[19:0],
               bus.busy, bus.err_timeout, bus.err_mode},
              32'd0);
        check("reset_frame_hi", {bus.frame_data[23:20], bus.frame_len, bus.frame_crc}, 11'd0);
        reset_tx = 1'b0;

        // Table runs straight from reset, so rolling counter equals the index.
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: no done pulse ever arrives.
        @(negedge clk_tx);
        bus.cfg_mode = 3'b010;
        bus.enable   = 1'b1;
        @(negedge clk_tx);
        bus.enable   = 1'b0;
        load_cycles  = 0;
        n            = 0;
        while (!bus.err_timeout && n < 200) begin
            if (bus.load_bit == 3'b010) load_cycles++;
            @(negedge clk_tx);
            n++;
        end
        check("timeout_pulse", bus.err_timeout, 1'b1);
        check("timeout_load_cycles", load_cycles, 64);
        check("timeout_load_bit", bus.load_bit, 3'd0);
        saw_valid = 1'b0;
        @(negedge clk_tx);
        check("timeout_pulse_end", bus.err_timeout, 1'b0);
        check("timeout_idle", bus.busy, 1'b0);
        repeat (10) begin
            saw_valid = saw_valid | bus.frame_valid;
            @(negedge clk_tx);
        end
        check("timeout_no_frame", saw_valid, 1'b0);

        // Mode 0 request is rejected.
        bus.cfg_mode   = 3'd0;
        bus.cfg_status = 4'h9;
        bus.enable     = 1'b1;
        @(negedge clk_tx);
        bus.enable = 1'b0;
        check("err_mode_pulse", bus.err_mode, 1'b1);
        check("err_mode_no_load", bus.load_bit, 3'd0);
        check("err_mode_idle", bus.busy, 1'b0);
        @(negedge clk_tx);
        check("err_mode_pulse_end", bus.err_mode, 1'b0);

        // Reset asserted while the CRC is being computed.
        bus.frame_ready = 1'b1;
        bus.cfg_mode    = 3'b001;
        bus.cfg_status  = 4'hA;
        bus.enable      = 1'b1;
        @(negedge clk_tx);
        bus.enable   = 1'b0;
        bus.cfg_mode = 3'd0;
        @(negedge clk_tx);
        bus.done    = 1'b1;
        bus.data_f1 = 16'h0ABC;
        bus.data_f2 = 12'h123;
        @(negedge clk_tx);
        bus.done = 1'b0;
        @(negedge clk_tx);
        check("pre_reset_data", bus.frame_data, 24'hABC321);
        reset_tx = 1'b1;
        #1;
        check("crc_reset_outputs",
              {bus.load_bit, bus.frame_valid, bus.frame_status, bus.frame_data[19:0],
               bus.busy, bus.err_timeout, bus.err_mode},
              32'd0);
        check("crc_reset_frame_hi", {bus.frame_data[23:20], bus.frame_len, bus.frame_crc}, 11'd0);
        @(negedge clk_tx);
        reset_tx = 1'b0;
        repeat (8) @(negedge clk_tx);
        check("crc_reset_no_frame", bus.frame_valid, 1'b0);

        // Rolling counter restarts at 0 and steps once per accepted frame.
        v = '{3'b011, 4'hC, 16'h0555, 12'h000, 0, 24'h555000, 3'd4, 1'b0, 4'h0};
        run_vec(v, "rcnt0");
        v.exp_data = 24'h555100;
        run_vec(v, "rcnt1");

        repeat (3) @(negedge clk_tx);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
